// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the N-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int unsigned CNT_W    = 4;
    localparam logic [3:0]  LOSS_SAT = 4'd15;

    // Saturating increment for the per-port loss counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == LOSS_SAT) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_n_if.sv
// Requester-side and physical-memory-side signals of the N-port arbiter.
interface mem_arbiter_n_if #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 256
);
    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]        req_read;
    logic [NUM_PORTS-1:0]        req_write;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        req_resp;
    logic [DATA_W-1:0]           req_rdata;
    logic                        pmem_read;
    logic                        pmem_write;
    logic [ADDR_W-1:0]           pmem_address;
    logic [DATA_W-1:0]           pmem_wdata;
    logic [DATA_W-1:0]           pmem_rdata;
    logic                        pmem_resp;
    logic [IDX_W-1:0]            grant_id;
    logic                        busy;

    // Arbiter side.
    modport master (
        input  req_read, req_write, req_addr, req_wdata, pmem_rdata, pmem_resp,
        output req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
               grant_id, busy
    );

    // Requesters plus memory model side.
    modport slave (
        output req_read, req_write, req_addr, req_wdata, pmem_rdata, pmem_resp,
        input  req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata,
               grant_id, busy
    );

endinterface

// File: rtl/arb_picker.sv
// Combinational winner selection: starved ports first, then round robin or fixed priority.
module arb_picker #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned RR_MODE   = 1
) (
    input  logic [NUM_PORTS-1:0]         pending,
    input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
    input  logic [NUM_PORTS-1:0]         starved,
    output logic                         valid_c,
    output logic [$clog2(NUM_PORTS)-1:0] winner_c
);
    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] hungry;
    int unsigned          rr_idx;
    logic [IDX_W-1:0]     rr_pos;

    assign hungry = pending & starved;

    // Loops run downward so the lowest index / shortest distance is written last and wins.
    always_comb begin
        valid_c  = |pending;
        winner_c = '0;
        rr_idx   = 0;
        rr_pos   = '0;
        if (|hungry) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (hungry[i]) winner_c = IDX_W'(i);
            end
        end else if (RR_MODE != 0) begin
            for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
                rr_idx = (32'(last_grant) + k) % NUM_PORTS;
                rr_pos = IDX_W'(rr_idx);
                if (pending[rr_pos]) winner_c = rr_pos;
            end
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (pending[i]) winner_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port arbiter in front of the single physical-memory port: FSM, command latch,
// loss counters for starvation protection and response routing.
module mem_arbiter_n
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned RR_MODE      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic            clk,
    input logic            rst,
    mem_arbiter_n_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    state_t              state;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    grant_q;
    logic                busy_q;
    logic                rd_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    loss_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] starved;
    logic [NUM_PORTS-1:0] resp_c;
    logic                 pick_valid_c;
    logic [IDX_W-1:0]     pick_win_c;
    logic [ADDR_W-1:0]    sel_addr_c;
    logic [DATA_W-1:0]    sel_wdata_c;
    logic                 sel_rd_c;
    logic                 sel_wr_c;

    assign pending = bus.req_read | bus.req_write;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            starved[i] = (loss_cnt[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .RR_MODE   (RR_MODE)
    ) u_picker (
        .pending    (pending),
        .last_grant (last_grant),
        .starved    (starved),
        .valid_c    (pick_valid_c),
        .winner_c   (pick_win_c)
    );

    // Winner's command mux.
    always_comb begin
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        sel_rd_c    = 1'b0;
        sel_wr_c    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_win_c == IDX_W'(i)) begin
                sel_addr_c  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_c = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_rd_c    = bus.req_read[i];
                sel_wr_c    = bus.req_write[i];
            end
        end
    end

    // FSM with the command latch; a write wins over a simultaneous read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            grant_q    <= '0;
            busy_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) loss_cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid_c) begin
                        state      <= BUSY;
                        busy_q     <= 1'b1;
                        grant_q    <= pick_win_c;
                        last_grant <= pick_win_c;
                        wr_q       <= sel_wr_c;
                        rd_q       <= sel_rd_c & ~sel_wr_c;
                        addr_q     <= sel_addr_c;
                        wdata_q    <= sel_wdata_c;
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            if (pick_win_c == IDX_W'(i)) loss_cnt[i] <= '0;
                            else if (pending[i])         loss_cnt[i] <= sat_inc(loss_cnt[i]);
                            else                         loss_cnt[i] <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.pmem_resp) begin
                        state   <= RELEASE;
                        busy_q  <= 1'b0;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        grant_q <= '0;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Completion pulse goes only to the granted port, and only while BUSY.
    always_comb begin
        resp_c = '0;
        if (state == BUSY && bus.pmem_resp) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                resp_c[i] = (grant_q == IDX_W'(i));
            end
        end
    end

    assign bus.req_resp     = resp_c;
    assign bus.req_rdata    = bus.pmem_rdata;
    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: a 2-port round-robin instance and a 3-port fixed-priority instance.
module tb_mem_arbiter_n;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 256;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_n_if #(.NUM_PORTS(2), .ADDR_W(AW), .DATA_W(DW)) ia ();
    mem_arbiter_n_if #(.NUM_PORTS(3), .ADDR_W(AW), .DATA_W(DW)) ib ();

    mem_arbiter_n #(.NUM_PORTS(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .STARVE_LIMIT(4))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    mem_arbiter_n #(.NUM_PORTS(3), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .STARVE_LIMIT(4))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ia.req_read = '0; ia.req_write = '0; ia.req_addr = '0; ia.req_wdata = '0;
        ia.pmem_resp = 1'b0; ia.pmem_rdata = '0;
        ib.req_read = '0; ib.req_write = '0; ib.req_addr = '0; ib.req_wdata = '0;
        ib.pmem_resp = 1'b0; ib.pmem_rdata = '0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] rd_pat;
        rd_pat = {8{32'hDEAD_BEEF}};
        rst = 1'b1;
        idle_inputs();
        step(); step();
        rst = 1'b0;
        step();
        ia.pmem_resp = 1'b1; ib.pmem_resp = 1'b1;
        ia.pmem_rdata = rd_pat; ib.pmem_rdata = rd_pat;
        #1;
        checks++;
        if ({ia.busy, ia.pmem_read, ia.pmem_write, ia.grant_id, ia.req_resp} !== '0) begin
            errors++;
            $display("FAIL reset_a_ctrl: got %0h required 0",
                     {ia.busy, ia.pmem_read, ia.pmem_write, ia.grant_id, ia.req_resp});
        end
        checks++;
        if ({ia.pmem_address, ia.pmem_wdata} !== '0) begin
            errors++; $display("FAIL reset_a_data: addr %0h wdata %0h required 0", ia.pmem_address, ia.pmem_wdata);
        end
        checks++;
        if ({ib.busy, ib.pmem_read, ib.pmem_write, ib.grant_id, ib.req_resp} !== '0) begin
            errors++;
            $display("FAIL reset_b_ctrl: got %0h required 0",
                     {ib.busy, ib.pmem_read, ib.pmem_write, ib.grant_id, ib.req_resp});
        end
        checks++;
        if ({ib.pmem_address, ib.pmem_wdata} !== '0) begin
            errors++; $display("FAIL reset_b_data: addr %0h wdata %0h required 0", ib.pmem_address, ib.pmem_wdata);
        end
        checks++;
        if (ia.req_rdata !== rd_pat || ib.req_rdata !== rd_pat) begin
            errors++; $display("FAIL rdata_passthrough: a %0h b %0h required %0h", ia.req_rdata, ib.req_rdata, rd_pat);
        end
        step();
        checks++;
        if (ia.busy !== 1'b0 || ib.busy !== 1'b0) begin
            errors++; $display("FAIL resp_in_idle: busy a %0b b %0b required 0", ia.busy, ib.busy);
        end
        ia.pmem_resp = 1'b0; ib.pmem_resp = 1'b0;
    endtask

    task automatic test_rr_alternate();
        int         exp_g [4] = '{0, 1, 0, 1};
        logic [1:0] exp_resp;
        bit         ok;
        ia.req_read = 2'b11;
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin step(); ok = ia.busy; end
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_first_grant: busy 0 after 8 cycles required 1"); end
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (32'(ia.grant_id) !== exp_g[t]) begin
                errors++; $display("FAIL rr_grant_%0d: grant_id %0d required %0d", t, ia.grant_id, exp_g[t]);
            end
            checks++;
            if (ia.pmem_read !== 1'b1 || ia.pmem_write !== 1'b0) begin
                errors++; $display("FAIL rr_strobe_%0d: read %0b write %0b required 1 0", t, ia.pmem_read, ia.pmem_write);
            end
            if (t == 3) ia.req_read = 2'b00;
            ia.pmem_resp = 1'b1;
            #1;
            exp_resp = 2'b01 << exp_g[t];
            checks++;
            if (ia.req_resp !== exp_resp) begin
                errors++; $display("FAIL rr_resp_%0d: req_resp %b required %b", t, ia.req_resp, exp_resp);
            end
            step();
            ia.pmem_resp = 1'b0;
            checks++;
            if ({ia.busy, ia.pmem_read, ia.pmem_write, ia.req_resp} !== '0) begin
                errors++; $display("FAIL rr_release_%0d: busy/rd/wr/resp %b required 0", t,
                                   {ia.busy, ia.pmem_read, ia.pmem_write, ia.req_resp});
            end
            step();
            checks++;
            if (ia.busy !== 1'b0) begin
                errors++; $display("FAIL rr_idle_%0d: busy %0b required 0", t, ia.busy);
            end
            step();
            checks++;
            if (ia.busy !== (t < 3)) begin
                errors++; $display("FAIL rr_regrant_%0d: busy %0b required %0b", t, ia.busy, (t < 3));
            end
        end
    endtask

    task automatic test_starvation();
        int         exp_g [5] = '{0, 0, 0, 0, 2};
        logic [2:0] exp_resp;
        bit         ok;
        rst = 1'b1; step(); rst = 1'b0;
        ib.req_read = 3'b101;
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin step(); ok = ib.busy; end
        checks++;
        if (!ok) begin errors++; $display("FAIL starve_first_grant: busy 0 after 8 cycles required 1"); end
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (32'(ib.grant_id) !== exp_g[t]) begin
                errors++; $display("FAIL starve_grant_%0d: grant_id %0d required %0d", t, ib.grant_id, exp_g[t]);
            end
            if (t == 4) ib.req_read = 3'b000;
            ib.pmem_resp = 1'b1;
            #1;
            exp_resp = 3'b001 << exp_g[t];
            checks++;
            if (ib.req_resp !== exp_resp) begin
                errors++; $display("FAIL starve_resp_%0d: req_resp %b required %b", t, ib.req_resp, exp_resp);
            end
            step();
            ib.pmem_resp = 1'b0;
            step(); step();
        end
        checks++;
        if (ib.busy !== 1'b0) begin errors++; $display("FAIL starve_end_idle: busy %0b required 0", ib.busy); end
    endtask

    task automatic test_cmd_latch_and_stall();
        logic [DW-1:0] pat;
        bit            ok;
        pat = {32{8'hA5}};
        ib.req_addr = '0;
        ib.req_addr[AW +: AW] = 32'h0000_1040;
        ib.req_wdata = '0;
        ib.req_wdata[DW +: DW] = pat;
        ib.req_write = 3'b010;
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin step(); ok = ib.busy; end
        checks++;
        if (!ok) begin errors++; $display("FAIL latch_grant: busy 0 after 8 cycles required 1"); end
        checks++;
        if (ib.grant_id !== 2'd1 || ib.pmem_write !== 1'b1 || ib.pmem_read !== 1'b0) begin
            errors++; $display("FAIL latch_cmd: grant %0d wr %0b rd %0b required 1 1 0", ib.grant_id, ib.pmem_write, ib.pmem_read);
        end
        checks++;
        if (ib.pmem_address !== 32'h0000_1040 || ib.pmem_wdata !== pat) begin
            errors++; $display("FAIL latch_data: addr %0h wdata %0h required 1040 %0h", ib.pmem_address, ib.pmem_wdata, pat);
        end
        ib.req_addr[AW +: AW] = 32'h0000_2000;
        ib.req_wdata[DW +: DW] = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (ib.busy !== 1'b1 || ib.grant_id !== 2'd1 || ib.pmem_address !== 32'h0000_1040 || ib.pmem_wdata !== pat) begin
                errors++; $display("FAIL stall_hold_%0d: busy %0b grant %0d addr %0h required 1 1 1040", c,
                                   ib.busy, ib.grant_id, ib.pmem_address);
            end
        end
        ib.req_write = 3'b000;
        ib.pmem_resp = 1'b1;
        #1;
        checks++;
        if (ib.req_resp !== 3'b010) begin
            errors++; $display("FAIL stall_resp: req_resp %b required 010", ib.req_resp);
        end
        step();
        ib.pmem_resp = 1'b0;
        checks++;
        if ({ib.busy, ib.pmem_read, ib.pmem_write, ib.grant_id, ib.req_resp} !== '0) begin
            errors++; $display("FAIL stall_release: busy/rd/wr/grant/resp %b required 0",
                               {ib.busy, ib.pmem_read, ib.pmem_write, ib.grant_id, ib.req_resp});
        end
        step();
        checks++;
        if (ib.busy !== 1'b0) begin errors++; $display("FAIL stall_idle: busy %0b required 0", ib.busy); end
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        ib.req_addr = '0;
        ib.req_addr[0 +: AW] = 32'h0000_3000;
        ib.req_read = 3'b001;
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin step(); ok = ib.busy; end
        step(); step();
        checks++;
        if (!ok || ib.busy !== 1'b1 || ib.pmem_address !== 32'h0000_3000) begin
            errors++; $display("FAIL rstbusy_pre: busy %0b addr %0h required 1 3000", ib.busy, ib.pmem_address);
        end
        rst = 1'b1;
        ib.req_read = 3'b000;
        step();
        rst = 1'b0;
        checks++;
        if ({ib.busy, ib.pmem_read, ib.pmem_write, ib.grant_id, ib.req_resp} !== '0 || ib.pmem_address !== '0) begin
            errors++; $display("FAIL rstbusy_clear: busy/rd/wr/grant/resp %b addr %0h required 0",
                               {ib.busy, ib.pmem_read, ib.pmem_write, ib.grant_id, ib.req_resp}, ib.pmem_address);
        end
        ib.pmem_resp = 1'b1;
        #1;
        checks++;
        if (ib.req_resp !== 3'b000) begin
            errors++; $display("FAIL rstbusy_late_resp: req_resp %b required 000", ib.req_resp);
        end
        step();
        checks++;
        if (ib.req_resp !== 3'b000 || ib.busy !== 1'b0) begin
            errors++; $display("FAIL rstbusy_after: req_resp %b busy %0b required 000 0", ib.req_resp, ib.busy);
        end
        ib.pmem_resp = 1'b0;
        step();
    endtask

    task automatic test_read_write_both();
        bit ok;
        ib.req_read  = 3'b001;
        ib.req_write = 3'b001;
        if ((ib.req_read & ib.req_write) != 3'b000)
            $display("note: protocol error, port 0 drives read and write together");
        ok = 1'b0;
        for (int c = 0; c < 8 && !ok; c++) begin step(); ok = ib.busy; end
        checks++;
        if (!ok || ib.grant_id !== 2'd0) begin
            errors++; $display("FAIL rw_grant: busy %0b grant %0d required 1 0", ib.busy, ib.grant_id);
        end
        checks++;
        if (ib.pmem_write !== 1'b1 || ib.pmem_read !== 1'b0) begin
            errors++; $display("FAIL rw_write_wins: wr %0b rd %0b required 1 0", ib.pmem_write, ib.pmem_read);
        end
        ib.req_read = 3'b000; ib.req_write = 3'b000;
        ib.pmem_resp = 1'b1;
        step();
        ib.pmem_resp = 1'b0;
        step(); step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rr_alternate();
        test_starvation();
        test_cmd_latch_and_stall();
        test_reset_mid_busy();
        test_read_write_both();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_n.md
# mem_arbiter_n

Parametrised N-port arbiter between the cache hierarchy (I-cache, D-cache, prefetch/victim ports) and the single physical-memory port. It selects one requester per transaction by fixed priority or round robin, with starvation protection. It latches the winner's command for the whole transaction and routes the memory response back to that port only. It replaces the fixed two-port I/D arbiter and adds a one-cycle release state between transactions.

## Interface
- NUM_PORTS, 2: number of requesters (2..8); port 0 is highest fixed priority.
- ADDR_W, 32: address width.
- DATA_W, 256: cache-line width.
- RR_MODE, 1: 1 = round robin, 0 = fixed priority.
- STARVE_LIMIT, 4: number of consecutive losses after which a requester is force-granted (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_read  in  NUM_PORTS  per-port read request.
- req_write  in  NUM_PORTS  per-port write request.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  per-port write line.
- req_resp  out  NUM_PORTS  one-hot completion pulse to the granted port.
- req_rdata  out  DATA_W  pmem_rdata broadcast to all ports; valid with req_resp.
- pmem_read  out  1  memory read.
- pmem_write  out  1  memory write.
- pmem_address  out  ADDR_W  latched address.
- pmem_wdata  out  DATA_W  latched write data.
- pmem_rdata  in  DATA_W  memory read data.
- pmem_resp  in  1  memory completion.
- grant_id  out  $clog2(NUM_PORTS)  index of the granted port; 0 when not BUSY.
- busy  out  1  high in BUSY.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: a port is pending when req_read[i] or req_write[i] is high. If any port is pending, the picker selects a winner. The arbiter latches the winner's index, op, address and wdata, then goes to BUSY. If no port is pending, it stays in IDLE.
- Picker order:
  - Starved ports first: any pending port whose loss counter is at or above STARVE_LIMIT; lowest index among them wins.
  - Otherwise, RR_MODE=1: search from last_grant+1 with wrap-around (NUM_PORTS-1 wraps to 0).
  - Otherwise, RR_MODE=0: lowest pending index wins.
- Loss counters: on each grant, every other pending port increments its counter, saturating at 15. The winner's counter clears to 0. Non-pending ports clear to 0.
- BUSY:
  - pmem_read or pmem_write is driven from the latched op. pmem_address and pmem_wdata come from the latched values.
  - Requester input changes are ignored.
  - When pmem_resp is high, req_resp[grant] equals pmem_resp, and the state goes to RELEASE.
- RELEASE: all pmem_* strobes and req_resp are 0. The next state is IDLE unconditionally, which gives the requester one cycle to drop its request.
- Read and write both high on the winning port: the write wins and the read is dropped. The bench flags this as a protocol error.
- pmem_resp outside BUSY is ignored.
- Grants go only to pending ports; the arbiter never grants a port with no request.

## Timing
- Reset values: state IDLE, last_grant NUM_PORTS-1 (so port 0 wins first in RR), loss counters 0. All outputs are 0: req_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, grant_id, busy. req_rdata passes pmem_rdata through.
- Request sampled in IDLE at edge t: BUSY, busy and pmem strobe are all asserted after edge t (1-cycle grant latency).
- pmem_resp in cycle k: req_resp[grant] is high in cycle k (combinational). RELEASE in k+1, IDLE in k+2. The earliest next grant is visible in k+3.
- Minimum transaction length with a 1-cycle memory: 4 cycles, request to next grant.
- Reset mid-BUSY: next cycle is IDLE with all outputs 0. Any in-flight pmem_resp is dropped, and the requester re-issues.
- pmem_* outputs are glitch-free: they are driven only from registered state and latched command.

## Structure
- Package mem_arb_pkg holds the state enum (IDLE, BUSY, RELEASE) and the saturation constant 4'd15.
- Sub-module arb_picker (combinational) takes pending, last_grant, starved and RR_MODE, and returns a valid flag and the winner index.
- The top level holds the FSM, the command latch, the loss counters and the response routing.

## Test plan
- NUM_PORTS=2, RR_MODE=1: both ports request continuously, 1-cycle memory -> grant order 0,1,0,1. req_resp is never high on both ports in one cycle.
- RR_MODE=0, STARVE_LIMIT=4, NUM_PORTS=3: ports 0 and 2 request continuously -> port 2 loses 4 times, then is granted on the 5th arbitration.
- Port 1 write to address 0x0000_1040 with wdata pattern 0xA5..: change req_addr to 0x2000 while BUSY -> pmem_address stays 0x1040 until pmem_resp.
- pmem_resp held low for 10 cycles -> busy stays high and grant_id stays constant. After resp: RELEASE for 1 cycle with strobes 0, then IDLE.
- rst asserted in the 3rd BUSY cycle -> all outputs 0 the following cycle. A pmem_resp arriving after reset produces no req_resp.
- Port 0 with read and write both high -> pmem_write=1 and pmem_read=0. The bench flags a protocol error.
